// File: rtl/fcvt_sw_seq.sv
// Iterative int32/uint32 to single-precision converter with a shared coarse/fine shifter.
// Define FCVT_DIRECTED_RM_EN to honour RTZ/RDN/RUP/RMM; otherwise rounding is RNE only.
module fcvt_sw_seq #(
  parameter int TAG_W  = 5,
  parameter int COARSE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_src,
  input  logic             req_unsigned,
  input  logic [2:0]       req_rm,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [4:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [31:0]        r_mag;
  logic [7:0]         r_exp;
  logic               r_sign;
  logic [TAG_W-1:0]   r_tag;
  logic [31:0]        r_result;
  logic [4:0]         r_flags;
  logic               r_rspValid;
`ifdef FCVT_DIRECTED_RM_EN
  logic [2:0]         r_rm;
`endif

  logic               w_accept;
  logic               w_acceptSign;
  logic [31:0]        w_acceptMag;
  logic               w_coarseZero;
  logic               w_lsb;
  logic               w_g;
  logic               w_s;
  logic               w_inc;
  logic [30:0]        w_rounded;

  assign req_ready    = (r_state == IDLE) && !flush;
  assign busy         = (r_state != IDLE);
  assign rsp_valid    = r_rspValid;
  assign rsp_result   = r_result;
  assign rsp_flags    = r_flags;
  assign rsp_tag      = r_tag;

  assign w_accept     = req_valid && req_ready;
  assign w_acceptSign = req_src[31] && !req_unsigned;
  assign w_acceptMag  = w_acceptSign ? (~req_src + 32'd1) : req_src;
  assign w_coarseZero = (r_mag[31 -: COARSE] == '0);

  assign w_lsb = r_mag[8];
  assign w_g   = r_mag[7];
  assign w_s   = |r_mag[6:0];

  // Round increment; unknown directed codes fall back to nearest-even.
`ifdef FCVT_DIRECTED_RM_EN
  always_comb begin
    w_inc = w_g & (w_s | w_lsb);
    case (r_rm)
      3'b001:  w_inc = 1'b0;
      3'b010:  w_inc = r_sign & (w_g | w_s);
      3'b011:  w_inc = !r_sign & (w_g | w_s);
      3'b100:  w_inc = w_g;
      default: w_inc = w_g & (w_s | w_lsb);
    endcase
  end
`else
  assign w_inc = w_g & (w_s | w_lsb);
`endif

  // Mantissa carry ripples into the exponent field, giving the renormalized result for free.
  assign w_rounded = {r_exp, r_mag[30:8]} + {30'd0, w_inc};

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_stateNext = (w_acceptMag == 32'd0) ? DONE : NORM;
      NORM:  if (r_mag[31]) w_stateNext = ROUND;
      ROUND: w_stateNext = DONE;
      DONE:  if (rsp_ready) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
    if (flush) w_stateNext = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rspValid <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_rspValid <= (w_stateNext == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mag    <= 32'd0;
      r_exp    <= 8'd0;
      r_sign   <= 1'b0;
      r_tag    <= '0;
      r_result <= 32'd0;
      r_flags  <= 5'd0;
`ifdef FCVT_DIRECTED_RM_EN
      r_rm     <= 3'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sign <= w_acceptSign;
            r_mag  <= w_acceptMag;
            r_exp  <= 8'd158;
            r_tag  <= req_tag;
`ifdef FCVT_DIRECTED_RM_EN
            r_rm   <= req_rm;
`endif
            if (w_acceptMag == 32'd0) begin
              r_result <= 32'd0;
              r_flags  <= 5'd0;
            end
          end
        end
        NORM: begin
          if (!r_mag[31]) begin
            if (w_coarseZero) begin
              r_mag <= r_mag << COARSE;
              r_exp <= r_exp - 8'(COARSE);
            end else begin
              r_mag <= r_mag << 1;
              r_exp <= r_exp - 8'd1;
            end
          end
        end
        ROUND: begin
          r_result <= {r_sign, w_rounded};
          r_flags  <= {4'b0000, w_g | w_s};
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fcvt_sw_seq.sv
// Self-checking bench for fcvt_sw_seq: directed test-plan cases, random conversions
// against an arithmetic reference model, DONE hold, flush and async reset aborts.
module tb_fcvt_sw_seq;

  localparam int TAG_W  = 5;
  localparam int COARSE = 8;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_src;
  logic             req_unsigned;
  logic [2:0]       req_rm;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [4:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;

  int checks = 0;
  int errors = 0;

  fcvt_sw_seq #(.TAG_W(TAG_W), .COARSE(COARSE)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_src(req_src),
    .req_unsigned(req_unsigned),
    .req_rm(req_rm),
    .req_tag(req_tag),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_result(rsp_result),
    .rsp_flags(rsp_flags),
    .rsp_tag(rsp_tag),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer magnitude, rounded to a 24-bit significand by remainder comparison.
  function automatic logic [36:0] refConvert(input logic [31:0] src, input logic uns,
                                             input logic [2:0] rm);
    logic        sgn;
    logic [63:0] m;
    logic [63:0] q;
    logic [63:0] rem;
    logic [63:0] half;
    logic [7:0]  e;
    logic        up;
    logic [2:0]  mode;
    int          p;
    int          sh;
    sgn = src[31] && !uns;
    m = sgn ? (64'd4294967296 - {32'd0, src}) : {32'd0, src};
    if (m == 64'd0) return 37'd0;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    if (p <= 23) begin
      q = m << (23 - p);
      rem = 64'd0;
      half = 64'd0;
    end else begin
      sh = p - 23;
      q = m >> sh;
      rem = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
    end
`ifdef FCVT_DIRECTED_RM_EN
    mode = (rm > 3'd4) ? 3'd0 : rm;
`else
    mode = 3'd0;
    if (rm == 3'd7) mode = 3'd0;
`endif
    up = 1'b0;
    if (rem != 64'd0) begin
      case (mode)
        3'd0: up = (rem > half) || (rem == half && q[0]);
        3'd1: up = 1'b0;
        3'd2: up = sgn;
        3'd3: up = !sgn;
        default: up = (rem >= half);
      endcase
    end
    q = q + {63'd0, up};
    e = 8'(127 + p);
    if (q[24]) begin
      q = q >> 1;
      e = e + 8'd1;
    end
    return {4'b0000, rem != 64'd0, sgn, e, q[22:0]};
  endfunction

  function automatic int refLatency(input logic [31:0] src, input logic uns);
    logic [31:0] m;
    int lz;
    m = (src[31] && !uns) ? (32'd0 - src) : src;
    if (m == 32'd0) return 1;
    lz = 0;
    while (!m[31 - lz]) lz++;
    return 3 + (lz / COARSE) + (lz % COARSE);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] src, input logic uns, input logic [2:0] rm,
                               input logic [TAG_W-1:0] tag);
    checkOutput("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_src = src;
    req_unsigned = uns;
    req_rm = rm;
    req_tag = tag;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_src = $urandom;
  endtask

  task automatic waitRsp(output int edges);
    edges = 1;
    while (rsp_valid !== 1'b1 && edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_dropped", {31'd0, rsp_valid}, 32'd0);
    checkOutput("busy_after_hs", {31'd0, busy}, 32'd0);
  endtask

  task automatic runConversion(input string name, input logic [31:0] src, input logic uns,
                               input logic [2:0] rm);
    logic [36:0]      exp;
    logic [TAG_W-1:0] tag;
    int               edges;
    exp = refConvert(src, uns, rm);
    tag = TAG_W'($urandom);
    applyStimulus(src, uns, rm, tag);
    waitRsp(edges);
    checkOutput({name, "_latency"}, 32'(edges), 32'(refLatency(src, uns)));
    checkOutput({name, "_result"}, rsp_result, exp[31:0]);
    checkOutput({name, "_flags"}, {27'd0, rsp_flags}, {27'd0, exp[36:32]});
    checkOutput({name, "_tag"}, {27'd0, rsp_tag}, {27'd0, tag});
    handshake();
  endtask

  initial begin
    logic [31:0] holdResult;
    logic        sawValid;
    int          edges;
    logic [31:0] rsrc;

    rst = 1'b1;
    flush = 1'b0;
    req_valid = 1'b0;
    req_src = 32'd0;
    req_unsigned = 1'b0;
    req_rm = 3'd0;
    req_tag = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset_rsp_result", rsp_result, 32'd0);
    checkOutput("reset_rsp_flags", {27'd0, rsp_flags}, 32'd0);
    checkOutput("reset_rsp_tag", {27'd0, rsp_tag}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
    flush = 1'b1;
    #1;
    checkOutput("req_ready_under_flush", {31'd0, req_ready}, 32'd0);
    flush = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    runConversion("s_one", 32'h00000001, 1'b0, 3'd0);
    checkOutput("s_one_const", rsp_result, 32'h3F800000);
    runConversion("s_minus1", 32'hFFFFFFFF, 1'b0, 3'd0);
    runConversion("u_max", 32'hFFFFFFFF, 1'b1, 3'd0);
    runConversion("s_tie", 32'h01000001, 1'b0, 3'd0);
    runConversion("s_tie_rup", 32'h01000001, 1'b0, 3'd3);
    runConversion("s_min", 32'h80000000, 1'b0, 3'd0);
    runConversion("zero", 32'h00000000, 1'b0, 3'd1);
    runConversion("s_neg_rdn", 32'hFEFFFFFF, 1'b0, 3'd2);
    runConversion("u_rmm", 32'h0300000A, 1'b1, 3'd4);

    for (int i = 0; i < 40; i++) begin
      rsrc = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) rsrc = 32'd0 - rsrc;
      runConversion("rand", rsrc, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    // Hold the response for five cycles, then accept back-to-back.
    applyStimulus(32'h00012345, 1'b0, 3'd0, 5'd21);
    waitRsp(edges);
    holdResult = rsp_result;
    checkOutput("hold_result_value", holdResult, 32'h4791A280);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("hold_result", rsp_result, 32'h4791A280);
      checkOutput("hold_tag", {27'd0, rsp_tag}, 32'd21);
      checkOutput("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    handshake();
    runConversion("b2b", 32'h00000300, 1'b1, 3'd0);

    // Flush while normalizing.
    applyStimulus(32'h00000001, 1'b0, 3'd0, 5'd3);
    checkOutput("norm_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    #1;
    checkOutput("flush_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_busy", {31'd0, busy}, 32'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) sawValid = 1'b1;
    end
    checkOutput("flush_no_rsp", {31'd0, sawValid}, 32'd0);
    runConversion("after_flush", 32'hFFFF8000, 1'b0, 3'd0);

    // Async reset while in ROUND (lz = 0: NORM then ROUND after two edges).
    applyStimulus(32'h80000000, 1'b1, 3'd0, 5'd9);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    #2;
    rst = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) sawValid = 1'b1;
    end
    checkOutput("rst_no_rsp", {31'd0, sawValid}, 32'd0);
    runConversion("after_rst", 32'h00ABCDEF, 1'b0, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
